// File: rtl/ext_input_conditioner.sv
// ext_input_conditioner: 2-FF synchroniser plus stable-count glitch filter on trigger, watchdog and instant-reset pins,
// latency pin->*_clean is 2+FILTER_CYCLES cycles (3 in bypass); edge pulses, saturating trigger count, watchdog timeout.
// No backpressure: free-running conditioner, every output is a register in the clk domain.
module ext_input_conditioner #(
    parameter int unsigned FILTER_CYCLES           = 16,
    parameter int unsigned WATCHDOG_TIMEOUT_CYCLES = 12500000,
    parameter int unsigned CNT_WIDTH               = 32
) (
    input  logic                 clk,
    input  logic                 peripheral_areset,
    input  logic                 trigger_pin,
    input  logic                 watchdog_pin,
    input  logic                 instant_reset_pin,
    input  logic                 filter_bypass,
    input  logic                 watchdog_enable,
    input  logic                 trigger_count_clear,
    output logic                 trigger_clean,
    output logic                 watchdog_clean,
    output logic                 instant_reset_clean,
    output logic                 trigger_rise,
    output logic                 trigger_fall,
    output logic [CNT_WIDTH-1:0] trigger_count,
    output logic                 watchdog_fail
);

    localparam int unsigned     WD_W      = $clog2(WATCHDOG_TIMEOUT_CYCLES + 1);
    localparam logic [7:0]      FILT_LAST = 8'(FILTER_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_LIMIT  = WD_W'(WATCHDOG_TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_ONE    = {{(WD_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Channel index: 0 = trigger, 1 = watchdog, 2 = instant reset
    logic [2:0]       pins;
    logic [2:0]       sync1_q;
    logic [2:0]       sync2_q;
    logic [2:0]       st_q, st_d;
    logic [2:0][7:0]  cnt_q, cnt_d;

    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    logic            wd_edge;
    logic            wd_en_q;
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            wd_fail_q, wd_fail_d;

    assign pins = {instant_reset_pin, watchdog_pin, trigger_pin};

    // Two-stage synchroniser; only sync2_q is used downstream
    always_ff @(posedge clk or posedge peripheral_areset) begin
        if (peripheral_areset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pins;
            sync2_q <= sync1_q;
        end
    end

    // Stable-count filter: state flips only after FILTER_CYCLES consecutive disagreeing samples
    always_comb begin
        st_d  = st_q;
        cnt_d = '0;
        for (int i = 0; i < 3; i++) begin
            if (filter_bypass) begin
                st_d[i] = sync2_q[i];
            end else if (sync2_q[i] != st_q[i]) begin
                if (cnt_q[i] == FILT_LAST) begin
                    st_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 8'd1;
                end
            end
        end
    end

    // Filter state and counters
    always_ff @(posedge clk or posedge peripheral_areset) begin
        if (peripheral_areset) begin
            st_q  <= '0;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
    end

    // Edge pulses coincide with the first cycle of the new filtered level; count lands after the rise cycle
    always_comb begin
        rise_d  = st_d[0] & ~st_q[0];
        fall_d  = ~st_d[0] & st_q[0];
        count_d = count_q;
        if (trigger_count_clear) begin
            count_d = '0;
        end else if (rise_q && (count_q != {CNT_WIDTH{1'b1}})) begin
            count_d = count_q + CNT_ONE;
        end
    end

    // Trigger edge pulse and counter registers
    always_ff @(posedge clk or posedge peripheral_areset) begin
        if (peripheral_areset) begin
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            count_q <= '0;
        end else begin
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            count_q <= count_d;
        end
    end

    // Watchdog: the first enabled cycle and every filtered edge restart the interval; edge beats timeout
    always_comb begin
        wd_edge   = st_d[1] ^ st_q[1];
        wd_cnt_d  = wd_cnt_q;
        wd_fail_d = wd_fail_q;
        if (!watchdog_enable) begin
            wd_cnt_d  = '0;
            wd_fail_d = 1'b0;
        end else if (wd_edge || !wd_en_q) begin
            wd_cnt_d  = '0;
            wd_fail_d = 1'b0;
        end else begin
            if (wd_cnt_q != WD_LIMIT) begin
                wd_cnt_d = wd_cnt_q + WD_ONE;
            end
            wd_fail_d = (wd_cnt_q == WD_LIMIT);
        end
    end

    // Watchdog interval counter, fail flag and enable history
    always_ff @(posedge clk or posedge peripheral_areset) begin
        if (peripheral_areset) begin
            wd_en_q   <= 1'b0;
            wd_cnt_q  <= '0;
            wd_fail_q <= 1'b0;
        end else begin
            wd_en_q   <= watchdog_enable;
            wd_cnt_q  <= wd_cnt_d;
            wd_fail_q <= wd_fail_d;
        end
    end

    assign trigger_clean       = st_q[0];
    assign watchdog_clean      = st_q[1];
    assign instant_reset_clean = st_q[2];
    assign trigger_rise        = rise_q;
    assign trigger_fall        = fall_q;
    assign trigger_count       = count_q;
    assign watchdog_fail       = wd_fail_q;

endmodule

// File: tb/tb_ext_input_conditioner.sv
// Testbench for ext_input_conditioner: directed scenarios plus a random phase,
// every cycle compared against a history-window reference model.
// Small parameters (filter 16, watchdog 100, counter 4 bits) keep the run short.
module tb_ext_input_conditioner;

    localparam int FC  = 16;
    localparam int WT  = 100;
    localparam int CW  = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          trigger_pin, watchdog_pin, instant_reset_pin;
    logic          filter_bypass, watchdog_enable, trigger_count_clear;
    logic          trigger_clean, watchdog_clean, instant_reset_clean;
    logic          trigger_rise, trigger_fall, watchdog_fail;
    logic [CW-1:0] trigger_count;

    ext_input_conditioner #(
        .FILTER_CYCLES(FC),
        .WATCHDOG_TIMEOUT_CYCLES(WT),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .peripheral_areset(rst),
        .trigger_pin(trigger_pin),
        .watchdog_pin(watchdog_pin),
        .instant_reset_pin(instant_reset_pin),
        .filter_bypass(filter_bypass),
        .watchdog_enable(watchdog_enable),
        .trigger_count_clear(trigger_count_clear),
        .trigger_clean(trigger_clean),
        .watchdog_clean(watchdog_clean),
        .instant_reset_clean(instant_reset_clean),
        .trigger_rise(trigger_rise),
        .trigger_fall(trigger_fall),
        .trigger_count(trigger_count),
        .watchdog_fail(watchdog_fail)
    );

    always #4 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: pin samples delayed two edges, full history of synchronised samples,
    // filtered level flips when the last FC samples all disagree with it.
    bit m_p1 [3];
    bit m_p2 [3];
    bit m_hist [3][$];
    bit m_clean [3];
    bit m_rise, m_fall, m_fail, m_en_prev;
    int m_count, m_start, t_edge;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_p1[i] = 1'b0;
            m_p2[i] = 1'b0;
            m_clean[i] = 1'b0;
            m_hist[i].delete();
        end
        m_rise = 1'b0;
        m_fall = 1'b0;
        m_fail = 1'b0;
        m_en_prev = 1'b0;
        m_count = 0;
        m_start = 0;
    endtask

    task automatic model_step();
        bit pins [3];
        bit old_clean [3];
        bit rise_prev;
        bit wd_edge;
        pins[0] = trigger_pin;
        pins[1] = watchdog_pin;
        pins[2] = instant_reset_pin;
        old_clean = m_clean;
        rise_prev = m_rise;
        t_edge++;
        for (int i = 0; i < 3; i++) begin
            bit s;
            bit all_diff;
            int sz;
            s = m_p2[i];
            m_hist[i].push_back(s);
            if (m_hist[i].size() > 256) void'(m_hist[i].pop_front());
            sz = m_hist[i].size();
            if (filter_bypass) begin
                m_clean[i] = s;
            end else if (sz >= FC) begin
                all_diff = 1'b1;
                for (int k = 0; k < FC; k++)
                    if (m_hist[i][sz-1-k] == old_clean[i]) all_diff = 1'b0;
                if (all_diff) m_clean[i] = !old_clean[i];
            end
        end
        m_p2 = m_p1;
        m_p1 = pins;
        m_rise = m_clean[0] && !old_clean[0];
        m_fall = !m_clean[0] && old_clean[0];
        if (trigger_count_clear) m_count = 0;
        else if (rise_prev && m_count < CMAX) m_count = m_count + 1;
        wd_edge = (m_clean[1] != old_clean[1]);
        if (!watchdog_enable) begin
            m_fail = 1'b0;
        end else if (wd_edge || !m_en_prev) begin
            m_start = t_edge;
            m_fail = 1'b0;
        end else begin
            m_fail = (t_edge - m_start) >= (WT + 1);
        end
        m_en_prev = watchdog_enable;
    endtask

    task automatic check_all();
        chk("trigger_clean", 32'(trigger_clean), 32'(m_clean[0]));
        chk("watchdog_clean", 32'(watchdog_clean), 32'(m_clean[1]));
        chk("instant_reset_clean", 32'(instant_reset_clean), 32'(m_clean[2]));
        chk("trigger_rise", 32'(trigger_rise), 32'(m_rise));
        chk("trigger_fall", 32'(trigger_fall), 32'(m_fall));
        chk("trigger_count", 32'(trigger_count), 32'(m_count));
        chk("watchdog_fail", 32'(watchdog_fail), 32'(m_fail));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int  n;
        bit  seen;
        logic prev;

        // Reset state
        rst = 1'b1;
        trigger_pin = 1'b0; watchdog_pin = 1'b0; instant_reset_pin = 1'b0;
        filter_bypass = 1'b0; watchdog_enable = 1'b0; trigger_count_clear = 1'b0;
        t_edge = 0;
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        repeat (5) tick();

        // Glitch of 15 cycles is rejected
        trigger_pin = 1'b1;
        repeat (15) tick();
        trigger_pin = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            seen |= trigger_rise;
        end
        chk("glitch_rise_seen", 32'(seen), 32'd0);
        chk("glitch_clean", 32'(trigger_clean), 32'd0);
        chk("glitch_count", 32'(trigger_count), 32'd0);

        // Accept with exact latency, one-cycle rise, count 1, then fall
        trigger_pin = 1'b1;
        n = 0;
        while (trigger_clean !== 1'b1 && n < 40) begin tick(); n++; end
        chk("rise_latency", n, 2 + FC);
        chk("rise_pulse", 32'(trigger_rise), 32'd1);
        tick();
        chk("rise_width", 32'(trigger_rise), 32'd0);
        chk("count_after_rise", 32'(trigger_count), 32'd1);
        repeat (5) tick();
        trigger_pin = 1'b0;
        n = 0;
        while (trigger_clean !== 1'b0 && n < 40) begin tick(); n++; end
        chk("fall_latency", n, 2 + FC);
        chk("fall_pulse", 32'(trigger_fall), 32'd1);
        tick();
        chk("fall_width", 32'(trigger_fall), 32'd0);

        // Bypass: one-cycle watchdog pulse appears 3 cycles later for 1 cycle
        filter_bypass = 1'b1;
        repeat (3) tick();
        watchdog_pin = 1'b1;
        tick();
        n = 1;
        watchdog_pin = 1'b0;
        while (watchdog_clean !== 1'b1 && n < 10) begin tick(); n++; end
        chk("bypass_latency", n, 3);
        tick();
        chk("bypass_width", 32'(watchdog_clean), 32'd0);
        filter_bypass = 1'b0;
        repeat (20) tick();

        // Random activity on all inputs, checked against the model every cycle
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) trigger_pin = ~trigger_pin;
            if ($urandom_range(0, 19) == 0) watchdog_pin = ~watchdog_pin;
            if ($urandom_range(0, 19) == 0) instant_reset_pin = ~instant_reset_pin;
            if ($urandom_range(0, 149) == 0) filter_bypass = ~filter_bypass;
            if ($urandom_range(0, 299) == 0) watchdog_enable = ~watchdog_enable;
            trigger_count_clear = ($urandom_range(0, 99) == 0);
            tick();
        end
        trigger_count_clear = 1'b0;
        filter_bypass = 1'b0;
        watchdog_enable = 1'b0;
        trigger_pin = 1'b0; watchdog_pin = 1'b0; instant_reset_pin = 1'b0;
        repeat (30) tick();

        // Watchdog: regular toggles keep fail low
        watchdog_enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            watchdog_pin = ~watchdog_pin;
            repeat (50) tick();
        end
        chk("wd_toggling_fail", 32'(watchdog_fail), 32'd0);
        // Last toggle, then timeout measured from its filtered edge
        prev = watchdog_clean;
        watchdog_pin = ~watchdog_pin;
        n = 0;
        while (watchdog_clean === prev && n < 40) begin tick(); n++; end
        chk("wd_edge_latency", n, 2 + FC);
        n = 0;
        while (watchdog_fail !== 1'b1 && n < 200) begin tick(); n++; end
        chk("wd_timeout", n, WT + 1);
        repeat (10) tick();
        // Resume toggling: fail clears on the first filtered edge
        chk("wd_fail_held", 32'(watchdog_fail), 32'd1);
        prev = watchdog_clean;
        watchdog_pin = ~watchdog_pin;
        n = 0;
        while (watchdog_clean === prev && n < 40) begin tick(); n++; end
        chk("wd_resume_latency", n, 2 + FC);
        chk("wd_fail_cleared", 32'(watchdog_fail), 32'd0);
        repeat (120) tick();
        chk("wd_fail_again", 32'(watchdog_fail), 32'd1);
        watchdog_enable = 1'b0;
        tick();
        chk("wd_disable_clears", 32'(watchdog_fail), 32'd0);
        repeat (5) tick();
        // Enable with no edges: fail WT+1 cycles after enable is sampled
        watchdog_enable = 1'b1;
        tick();
        n = 0;
        while (watchdog_fail !== 1'b1 && n < 200) begin tick(); n++; end
        chk("wd_enable_timeout", n, WT + 1);
        watchdog_enable = 1'b0;
        repeat (5) tick();

        // Counter saturation and clear-vs-rise priority, using bypass for speed
        filter_bypass = 1'b1;
        trigger_count_clear = 1'b1;
        tick();
        trigger_count_clear = 1'b0;
        for (int i = 0; i < 17; i++) begin
            trigger_pin = 1'b1;
            repeat (2) tick();
            trigger_pin = 1'b0;
            repeat (2) tick();
        end
        repeat (5) tick();
        chk("count_saturated", 32'(trigger_count), CMAX);
        trigger_pin = 1'b1;
        repeat (3) tick();
        chk("rise_for_clear", 32'(trigger_rise), 32'd1);
        trigger_count_clear = 1'b1;
        tick();
        trigger_count_clear = 1'b0;
        chk("clear_wins", 32'(trigger_count), 32'd0);
        tick();
        chk("clear_stays", 32'(trigger_count), 32'd0);
        trigger_pin = 1'b0;
        filter_bypass = 1'b0;
        repeat (30) tick();

        // Async reset mid-count while watchdog has failed
        watchdog_enable = 1'b1;
        n = 0;
        while (watchdog_fail !== 1'b1 && n < 200) begin tick(); n++; end
        chk("pre_reset_fail", 32'(watchdog_fail), 32'd1);
        trigger_pin = 1'b1;
        instant_reset_pin = 1'b1;
        repeat (12) tick();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("async_fail_zero", 32'(watchdog_fail), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        n = 0;
        seen = 1'b0;
        while (trigger_clean !== 1'b1 && n < 40) begin
            tick();
            n++;
            if (trigger_clean !== 1'b1) seen |= trigger_rise;
        end
        chk("post_reset_latency", n, 2 + FC);
        chk("post_reset_early_rise", 32'(seen), 32'd0);
        chk("post_reset_ir_clean", 32'(instant_reset_clean), 32'd1);
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
